// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_sweep_ctrl
// Purpose  : DDS waveform controller. It has an N-bit phase accumulator, a
//            phase offset, and four one-hot waveforms: sine from an external
//            ROM, plus arithmetic square, triangle and sawtooth. A built-in
//            linear frequency-sweep FSM runs either up-only with restart or
//            up/down.
// Ports    : clk, rst (sync, active high)
//            wave_sel[3:0]    one-hot waveform select (sin/squ/tri/saw)
//            fre_step[N]      static frequency word, used in IDLE
//            pha_step[M]      phase offset
//            sweep_en, sweep_tri, start, stop  sweep control
//            fre_start/fre_stop/fre_delta[N], dwell[DW_W]  sweep configuration
//            rom_addr[M] -> sine ROM (1-cycle registered read), rom_data[DW] <-
//            data_out[DW], data_valid       sample output
//            sweep_busy, sweep_wrap         sweep status
// Option   : AMP_SCALE_EN adds an amp input and a third amplitude-scale stage.
//            This raises the latency from 2 to 3 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 32,
    parameter int M          = 12,
    parameter int DW_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            wave_sel,
    input  logic [N-1:0]          fre_step,
    input  logic [M-1:0]          pha_step,
    input  logic                  sweep_en,
    input  logic                  sweep_tri,
    input  logic                  start,
    input  logic                  stop,
    input  logic [N-1:0]          fre_start,
    input  logic [N-1:0]          fre_stop,
    input  logic [N-1:0]          fre_delta,
    input  logic [DW_W-1:0]       dwell,
`ifdef AMP_SCALE_EN
    input  logic [DATA_WIDTH-1:0] amp,
`endif
    output logic [M-1:0]          rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  sweep_busy,
    output logic                  sweep_wrap
);

`ifdef AMP_SCALE_EN
    localparam logic [1:0] LAT = 2'd3;
`else
    localparam logic [1:0] LAT = 2'd2;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t                  state;
    logic [N-1:0]            fre_reg;
    logic [N-1:0]            fre_cur;
    logic [DW_W-1:0]         dwell_cnt;
    logic [DW_W-1:0]         dwell_last;
    logic                    step;
    logic [N:0]              up_sum;
    logic [N:0]              dn_diff;

    logic [N-1:0]            acc;
    logic [M-1:0]            phase_r;
    logic [DATA_WIDTH-1:0]   wave;
    logic [1:0]              vcnt;

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    assign fre_cur    = (state == IDLE) ? fre_step : fre_reg;
    // A dwell of 0 behaves like a dwell of 1: the FSM steps every cycle.
    assign dwell_last = (dwell == '0) ? '0 : dwell - DW_W'(1);
    assign step       = (dwell_cnt == dwell_last);
    // Step arithmetic uses one extra bit so the bound compares never wrap.
    assign up_sum     = {1'b0, fre_reg} + {1'b0, fre_delta};
    assign dn_diff    = {1'b0, fre_reg} - {1'b0, fre_delta};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fre_reg    <= '0;
            dwell_cnt  <= '0;
            sweep_busy <= 1'b0;
            sweep_wrap <= 1'b0;
        end else begin
            sweep_wrap <= 1'b0;
            if (stop || !sweep_en) begin
                state      <= IDLE;
                sweep_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && (fre_stop > fre_start)) begin
                            fre_reg    <= fre_start;
                            dwell_cnt  <= '0;
                            state      <= UP;
                            sweep_busy <= 1'b1;
                        end
                    end
                    UP: begin
                        if (step) begin
                            dwell_cnt <= '0;
                            if (fre_delta != '0) begin
                                // Up-only mode: the step after reaching the
                                // top restarts the ramp from the lower bound.
                                if (!sweep_tri && (fre_reg >= fre_stop)) begin
                                    fre_reg <= fre_start;
                                end else if (up_sum >= {1'b0, fre_stop}) begin
                                    fre_reg    <= fre_stop;
                                    sweep_wrap <= 1'b1;
                                    if (sweep_tri) begin
                                        state <= DOWN;
                                    end
                                end else begin
                                    fre_reg <= up_sum[N-1:0];
                                end
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + DW_W'(1);
                        end
                    end
                    DOWN: begin
                        if (step) begin
                            dwell_cnt <= '0;
                            if (fre_delta != '0) begin
                                if ($signed(dn_diff) <= $signed({1'b0, fre_start})) begin
                                    fre_reg <= fre_start;
                                    state   <= UP;
                                end else begin
                                    fre_reg <= dn_diff[N-1:0];
                                end
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + DW_W'(1);
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        sweep_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Phase accumulator and stage 1 (phase + offset, ROM address)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            phase_r <= '0;
        end else begin
            acc     <= acc + fre_cur;
            phase_r <= acc[N-1 -: M] + pha_step;
        end
    end

    // The ROM address is the stage-1 phase register itself.
    assign rom_addr = phase_r;

    // ------------------------------------------------------------------
    // Stage 2: waveform generation
    // ------------------------------------------------------------------
    always_comb begin
        wave = '0;
        case (wave_sel)
            4'b0001: wave = rom_data;
            4'b0010: wave = phase_r[M-1] ? '0 : '1;
            4'b0100: wave = phase_r[M-1] ? ~phase_r[M-2 -: DATA_WIDTH]
                                         :  phase_r[M-2 -: DATA_WIDTH];
            4'b1000: wave = phase_r[M-1 -: DATA_WIDTH];
            default: wave = '0;
        endcase
    end

`ifdef AMP_SCALE_EN
    logic [DATA_WIDTH-1:0]   wave_r;
    logic [DATA_WIDTH:0]     amp1;
    logic [2*DATA_WIDTH-1:0] prod;

    // amp+1 makes an all-ones amp an exact unity gain after the >> DATA_WIDTH.
    assign amp1 = {1'b0, amp} + {{DATA_WIDTH{1'b0}}, 1'b1};
    assign prod = {{DATA_WIDTH{1'b0}}, wave_r} * {{(DATA_WIDTH-1){1'b0}}, amp1};

    always_ff @(posedge clk) begin
        if (rst) begin
            wave_r   <= '0;
            data_out <= '0;
        end else begin
            wave_r   <= wave;
            data_out <= DATA_WIDTH'(prod >> DATA_WIDTH);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else begin
            data_out <= wave;
        end
    end
`endif

    // ------------------------------------------------------------------
    // data_valid rises once the pipeline has filled from the reset state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vcnt       <= '0;
            data_valid <= 1'b0;
        end else begin
            if (vcnt != LAT) begin
                vcnt <= vcnt + 2'd1;
            end
            data_valid <= (vcnt >= (LAT - 2'd1));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_sweep_ctrl
// Purpose  : Directed self-checking bench for dds_sweep_ctrl in its default
//            build (no amplitude stage): reset, waveforms, sweep modes,
//            stop/start handling and reset during a sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wave_sel;
    logic [31:0] fre_step;
    logic [11:0] pha_step;
    logic        sweep_en, sweep_tri, start, stop;
    logic [31:0] fre_start, fre_stop, fre_delta;
    logic [15:0] dwell;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data = 8'd0;
    logic [7:0]  data_out;
    logic        data_valid, sweep_busy, sweep_wrap;

    int total = 0;
    int bad   = 0;

    dds_sweep_ctrl #(.DATA_WIDTH(8), .N(32), .M(12), .DW_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wave_sel   (wave_sel),
        .fre_step   (fre_step),
        .pha_step   (pha_step),
        .sweep_en   (sweep_en),
        .sweep_tri  (sweep_tri),
        .start      (start),
        .stop       (stop),
        .fre_start  (fre_start),
        .fre_stop   (fre_stop),
        .fre_delta  (fre_delta),
        .dwell      (dwell),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sweep_busy (sweep_busy),
        .sweep_wrap (sweep_wrap)
    );

    always #5 clk = ~clk;

    // Registered-read ROM model: its data is the upper address byte.
    always @(posedge clk) rom_data <= rom_addr[11:4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        wave_sel = 4'b1000; fre_step = 32'h0100_0000; pha_step = 12'h000;
        sweep_en = 1'b0; sweep_tri = 1'b0; start = 1'b0; stop = 1'b0;
        fre_start = 32'd0; fre_stop = 32'd0; fre_delta = 32'd0; dwell = 16'd0;
        do_reset();
        total++; if (data_out !== 8'd0) begin bad++; $display("FAIL reset_data_out got=%0h exp=0", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
        total++; if (rom_addr !== 12'd0) begin bad++; $display("FAIL reset_rom_addr got=%0h exp=0", rom_addr); end
        total++; if (sweep_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", sweep_busy); end
        total++; if (sweep_wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", sweep_wrap); end
    endtask

    task automatic test_saw();
        wave_sel = 4'b1000; fre_step = 32'h0100_0000; pha_step = 12'h000;
        do_reset();
        tick();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL saw_valid_c1 got=%b exp=0", data_valid); end
        tick();
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL saw_valid_c2 got=%b exp=1", data_valid); end
        for (int j = 0; j < 300; j++) begin
            total++;
            if (data_out !== 8'(j)) begin bad++; $display("FAIL saw_sample j=%0d got=%0d exp=%0d", j, data_out, j % 256); end
            tick();
        end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL saw_valid_hold got=%b exp=1", data_valid); end
    endtask

    task automatic test_sin();
        wave_sel = 4'b0001; fre_step = 32'h0100_0000; pha_step = 12'h000;
        do_reset();
        repeat (3) tick();
        for (int j = 0; j < 20; j++) begin
            total++;
            if (data_out !== 8'(j)) begin bad++; $display("FAIL sin_sample j=%0d got=%0d exp=%0d", j, data_out, j); end
            tick();
        end
    endtask

    task automatic test_tri();
        logic [7:0] e;
        wave_sel = 4'b0100; fre_step = 32'h0080_0000; pha_step = 12'h000;
        do_reset();
        repeat (2) tick();
        for (int j = 0; j < 1024; j++) begin
            e = ((j % 512) < 256) ? 8'(j % 512) : 8'(511 - (j % 512));
            total++;
            if (data_out !== e) begin bad++; $display("FAIL tri_sample j=%0d got=%0d exp=%0d", j, data_out, e); end
            tick();
        end
    endtask

    task automatic test_squ();
        logic [7:0] e;
        wave_sel = 4'b0010; fre_step = 32'h0080_0000; pha_step = 12'h800;
        do_reset();
        repeat (2) tick();
        for (int j = 0; j < 512; j++) begin
            e = (j < 256) ? 8'h00 : 8'hFF;
            total++;
            if (data_out !== e) begin bad++; $display("FAIL squ_sample j=%0d got=%0h exp=%0h", j, data_out, e); end
            tick();
        end
        wave_sel = 4'b0110;
        repeat (2) tick();
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL bad_sel got=%0h exp=0", data_out); end
        pha_step = 12'h000;
    endtask

    task automatic test_sweep_saw();
        int tbl [0:7];
        tbl = '{100, 110, 120, 130, 100, 110, 120, 130};
        wave_sel = 4'b1000; fre_step = 32'd5;
        do_reset();
        sweep_en = 1'b1; sweep_tri = 1'b0;
        fre_start = 32'd100; fre_stop = 32'd130; fre_delta = 32'd10; dwell = 16'd3;
        start = 1'b1; tick(); start = 1'b0;
        total++; if (sweep_busy !== 1'b1) begin bad++; $display("FAIL ssaw_busy got=%b exp=1", sweep_busy); end
        total++; if (dut.fre_cur !== 32'd100) begin bad++; $display("FAIL ssaw_first got=%0d exp=100", dut.fre_cur); end
        for (int n = 1; n < 24; n++) begin
            tick();
            total++;
            if (dut.fre_cur !== 32'(tbl[n/3])) begin bad++; $display("FAIL ssaw_fre n=%0d got=%0d exp=%0d", n, dut.fre_cur, tbl[n/3]); end
            total++;
            if (sweep_wrap !== ((n == 9) || (n == 21))) begin bad++; $display("FAIL ssaw_wrap n=%0d got=%b exp=%b", n, sweep_wrap, (n == 9) || (n == 21)); end
        end
    endtask

    task automatic test_sweep_tri_stop();
        int tbl [0:7];
        tbl = '{100, 110, 120, 130, 120, 110, 100, 110};
        fre_step = 32'd7;
        do_reset();
        sweep_en = 1'b1; sweep_tri = 1'b1;
        fre_start = 32'd100; fre_stop = 32'd130; fre_delta = 32'd10; dwell = 16'd3;
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 1; n < 24; n++) begin
            tick();
            total++;
            if (dut.fre_cur !== 32'(tbl[n/3])) begin bad++; $display("FAIL stri_fre n=%0d got=%0d exp=%0d", n, dut.fre_cur, tbl[n/3]); end
            total++;
            if (sweep_wrap !== (n == 9)) begin bad++; $display("FAIL stri_wrap n=%0d got=%b exp=%b", n, sweep_wrap, n == 9); end
        end
        total++; if (sweep_busy !== 1'b1) begin bad++; $display("FAIL stri_busy got=%b exp=1", sweep_busy); end
        stop = 1'b1; tick(); stop = 1'b0;
        total++; if (sweep_busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b exp=0", sweep_busy); end
        total++; if (dut.fre_cur !== 32'd7) begin bad++; $display("FAIL stop_fre got=%0d exp=7", dut.fre_cur); end
        // stop takes priority over a simultaneous start
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        total++; if (sweep_busy !== 1'b0) begin bad++; $display("FAIL stop_wins got=%b exp=0", sweep_busy); end
    endtask

    task automatic test_sweep_ignore();
        sweep_en = 1'b1; sweep_tri = 1'b0;
        fre_start = 32'd200; fre_stop = 32'd100; fre_delta = 32'd10; dwell = 16'd3;
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            total++;
            if (sweep_busy !== 1'b0) begin bad++; $display("FAIL ignore_busy n=%0d got=%b exp=0", n, sweep_busy); end
            tick();
        end
        // dwell 0 behaves as 1: one step per cycle
        fre_start = 32'd100; fre_stop = 32'd130; dwell = 16'd0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        total++; if (dut.fre_cur !== 32'd110) begin bad++; $display("FAIL dwell0_fre got=%0d exp=110", dut.fre_cur); end
    endtask

    task automatic test_reset_mid_sweep();
        wave_sel = 4'b0010; fre_step = 32'd5;
        do_reset();
        sweep_en = 1'b1; sweep_tri = 1'b0;
        fre_start = 32'd100; fre_stop = 32'd130; fre_delta = 32'd10; dwell = 16'd3;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        total++; if (data_out !== 8'hFF) begin bad++; $display("FAIL pre_rst_data got=%0h exp=ff", data_out); end
        total++; if (sweep_busy !== 1'b1) begin bad++; $display("FAIL pre_rst_busy got=%b exp=1", sweep_busy); end
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (sweep_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", sweep_busy); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%0h exp=0", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", data_valid); end
        total++; if (rom_addr !== 12'd0) begin bad++; $display("FAIL mid_rst_addr got=%0h exp=0", rom_addr); end
        total++; if (sweep_wrap !== 1'b0) begin bad++; $display("FAIL mid_rst_wrap got=%b exp=0", sweep_wrap); end
    endtask

    initial begin
        test_reset();
        test_saw();
        test_sin();
        test_tri();
        test_squ();
        test_sweep_saw();
        test_sweep_tri_stop();
        test_sweep_ignore();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
